// File: rtl/dmx_frame_receiver_if.sv
// Single-cycle write port from the DMX frame receiver into the downstream channel buffer.
interface dmx_frame_receiver_if;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/dmx_frame_receiver.sv
// DMX512 frame receiver: deserialises start code and data slots after each break and writes slots
// to the channel buffer. Optional macro DMX_RX_START_CODE_FILTER_EN suppresses non-zero start-code frames.
module dmx_frame_receiver #(
  parameter int CLK_FREQ  = 20_000_000,
  parameter int BAUD      = 250_000,
  parameter int MAX_SLOTS = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 break_valid,
  dmx_frame_receiver_if.master wbuf,
  output logic [7:0]           start_code,
  output logic [9:0]           frame_slots,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int DATA_W      = 8;
  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [9:0]       SLOT_MAX  = 10'(MAX_SLOTS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START_BIT,
    DATA,
    STOP,
    WRITE
  } state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= SLOT_MAX) ? SLOT_MAX : v + 10'd1;
  endfunction

  state_t              state, state_n;
  logic                rx_p0, rx_s, rx_p2;
  logic                fall;
  logic [CNT_W-1:0]    cyc_cnt;
  logic [2:0]          bit_cnt;
  logic [9:0]          slot_idx;
  logic [DATA_W-1:0]   shift_p;
  logic                accept;

  logic                timer_clr, bit_clr, shift_en;
  logic                slot_clr, slot_inc, sc_latch;
  logic                done_set, err_set, slots_load, wr_fire;
  logic [9:0]          slots_val;

  // Stage p0/p1: two-flop synchroniser, p2 keeps the previous rx_s for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
      rx_p2 <= rx_s;
    end
  end

  assign fall = rx_p2 & ~rx_s;

`ifdef DMX_RX_START_CODE_FILTER_EN
  assign accept = (start_code == 8'h00);
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      slot_idx    <= '0;
      start_code  <= '0;
      frame_slots <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state   <= state_n;
      cyc_cnt <= timer_clr ? '0 : cyc_cnt + 1'b1;
      if (bit_clr)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 3'd1;
      if (slot_clr)
        slot_idx <= '0;
      else if (slot_inc)
        slot_idx <= sat_inc(slot_idx);
      if (sc_latch)
        start_code <= shift_p;
      if (slots_load)
        frame_slots <= slots_val;
      frame_done  <= done_set;
      frame_error <= err_set;
    end
  end

  // Stage p1: LSB-first shift register, data only
  always_ff @(posedge clk) begin
    if (shift_en)
      shift_p <= {rx_s, shift_p[DATA_W-1:1]};
  end

  always_comb begin
    state_n    = state;
    timer_clr  = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    slot_clr   = 1'b0;
    slot_inc   = 1'b0;
    sc_latch   = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    slots_load = 1'b0;
    slots_val  = '0;
    wr_fire    = 1'b0;

    if (break_valid) begin
      // A new break overrides everything; only completed writes are reported
      state_n  = WAIT_START;
      slot_clr = 1'b1;
      if (state != IDLE && slot_idx > 10'd1 && accept) begin
        done_set   = 1'b1;
        slots_load = 1'b1;
        slots_val  = slot_idx - 10'd1;
      end
    end else begin
      case (state)
        IDLE: ;
        WAIT_START: begin
          if (fall) begin
            state_n   = START_BIT;
            timer_clr = 1'b1;
            bit_clr   = 1'b1;
          end
        end
        START_BIT: begin
          if (cyc_cnt == HALF_LAST) begin
            timer_clr = 1'b1;
            state_n   = rx_s ? WAIT_START : DATA;
          end
        end
        DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            timer_clr = 1'b1;
            shift_en  = 1'b1;
            if (bit_cnt == 3'd7)
              state_n = STOP;
          end
        end
        STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            timer_clr = 1'b1;
            if (rx_s) begin
              if (slot_idx == 10'd0) begin
                sc_latch = 1'b1;
                slot_inc = 1'b1;
                state_n  = WAIT_START;
              end else begin
                state_n = WRITE;
              end
            end else if (shift_p == 8'h00 && slot_idx != 10'd0) begin
              // A zero byte with a low stop bit is the leading edge of the next break
              state_n = IDLE;
              if (accept) begin
                done_set   = 1'b1;
                slots_load = 1'b1;
                slots_val  = slot_idx - 10'd1;
              end
            end else begin
              err_set = 1'b1;
              state_n = IDLE;
            end
          end
        end
        WRITE: begin
          wr_fire = accept;
          if (slot_idx >= SLOT_MAX) begin
            state_n = IDLE;
            if (accept) begin
              done_set   = 1'b1;
              slots_load = 1'b1;
              slots_val  = SLOT_MAX;
            end
          end else begin
            slot_inc = 1'b1;
            state_n  = WAIT_START;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign wbuf.wr_en   = wr_fire;
  assign wbuf.wr_addr = wr_fire ? 9'(slot_idx - 10'd1) : 9'd0;
  assign wbuf.wr_data = wr_fire ? shift_p : 8'd0;

endmodule

// File: tb/tb_dmx_frame_receiver.sv
// Directed bench for dmx_frame_receiver: table of whole frames plus hand-written corner sequences.
module tb_dmx_frame_receiver;

  localparam int BITC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       break_valid = 1'b0;
  logic [7:0] start_code;
  logic [9:0] frame_slots;
  logic       frame_done, frame_error, busy;

  dmx_frame_receiver_if bus ();

  dmx_frame_receiver #(
    .CLK_FREQ (2_000_000),
    .BAUD     (250_000),
    .MAX_SLOTS(512)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .break_valid(break_valid),
    .wbuf       (bus),
    .start_code (start_code),
    .frame_slots(frame_slots),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  int         cyc = 0;
  logic [8:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int         last_wr_cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      last_wr_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_error) err_cnt++;
    if (frame_done && frame_error) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BITC);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pulse_break();
    break_valid = 1'b1;
    tick(1);
    break_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] sc;
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    bit         end_brk;
    int         exp_wr;
    int         exp_done;
    int         exp_slots;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bw, bd, be, errs, nchk;
    logic [7:0] e;

    // sc, slots, base, step, end by break, writes, done pulses, frame_slots afterwards
    vecs[0] = '{8'h00, 3, 8'h11, 8'h11, 1'b1, 3, 1, 3};
    vecs[1] = '{8'h00, 2, 8'h7E, 8'h01, 1'b0, 2, 1, 2};
    vecs[2] = '{8'h00, 0, 8'h00, 8'h00, 1'b1, 0, 0, 2};
`ifdef DMX_RX_START_CODE_FILTER_EN
    vecs[3] = '{8'hCC, 10, 8'h03, 8'h05, 1'b1, 0, 0, 2};
`else
    vecs[3] = '{8'hCC, 10, 8'h03, 8'h05, 1'b1, 10, 1, 10};
`endif
    vecs[4] = '{8'h00, 1, 8'h5C, 8'h00, 1'b1, 1, 1, 1};

    tick(3);
    sample();
    check("reset_wr_en", int'(bus.wr_en), 0);
    check("reset_wr_addr", int'(bus.wr_addr), 0);
    check("reset_wr_data", int'(bus.wr_data), 0);
    check("reset_start_code", int'(start_code), 0);
    check("reset_frame_slots", int'(frame_slots), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_frame_error", int'(frame_error), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(4);
    sample();
    check("idle_busy", int'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      bw = wa_q.size();
      bd = done_cnt;
      be = err_cnt;
      pulse_break();
      sample();
      check($sformatf("v%0d_busy_start", v), int'(busy), 1);
      tick(4);
      send_byte(vecs[v].sc, 1'b1);
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].base + 8'(i) * vecs[v].step, 1'b1);
      if (vecs[v].end_brk) begin
        pulse_break();
        sample();
        check($sformatf("v%0d_done_after_break", v), int'(frame_done), vecs[v].exp_done);
      end else begin
        send_byte(8'h00, 1'b0);
        tick(4);
        sample();
        check($sformatf("v%0d_busy_end", v), int'(busy), 0);
      end
      tick(2);
      sample();
      check($sformatf("v%0d_writes", v), wa_q.size() - bw, vecs[v].exp_wr);
      errs = 0;
      nchk = (wa_q.size() - bw < vecs[v].exp_wr) ? wa_q.size() - bw : vecs[v].exp_wr;
      for (int i = 0; i < nchk; i++) begin
        e = vecs[v].base + 8'(i) * vecs[v].step;
        if (int'(wa_q[bw+i]) != i || wd_q[bw+i] != e) errs++;
      end
      check($sformatf("v%0d_write_content_errors", v), errs, 0);
      check($sformatf("v%0d_frame_slots", v), int'(frame_slots), vecs[v].exp_slots);
      check($sformatf("v%0d_start_code", v), int'(start_code), int'(vecs[v].sc));
      check($sformatf("v%0d_done_count", v), done_cnt - bd, vecs[v].exp_done);
      check($sformatf("v%0d_error_count", v), err_cnt - be, 0);
    end

    // Full 512-slot frame ends on its own after the last write
    bw = wa_q.size();
    bd = done_cnt;
    pulse_break();
    tick(4);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    tick(4);
    sample();
    check("full_writes", wa_q.size() - bw, 512);
    errs = 0;
    for (int i = 0; i < 512 && bw + i < wa_q.size(); i++)
      if (int'(wa_q[bw+i]) != i || wd_q[bw+i] != 8'(i)) errs++;
    check("full_write_content_errors", errs, 0);
    check("full_done_count", done_cnt - bd, 1);
    check("full_done_latency", done_cyc - last_wr_cyc, 1);
    check("full_frame_slots", int'(frame_slots), 512);
    check("full_busy_after", int'(busy), 0);
    bw = wa_q.size();
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    tick(4);
    sample();
    check("full_no_writes_after", wa_q.size() - bw, 0);
    check("full_still_idle", int'(busy), 0);

    // Short low glitch while waiting for a start bit
    bw = wa_q.size();
    be = err_cnt;
    pulse_break();
    tick(4);
    send_byte(8'h00, 1'b1);
    tick(5);
    rx = 1'b0;
    tick(BITC / 4);
    rx = 1'b1;
    tick(2 * BITC);
    send_byte(8'h5A, 1'b1);
    tick(4);
    sample();
    check("glitch_writes", wa_q.size() - bw, 1);
    if (wa_q.size() > bw) begin
      check("glitch_addr", int'(wa_q[bw]), 0);
      check("glitch_data", int'(wd_q[bw]), 'h5A);
    end
    check("glitch_errors", err_cnt - be, 0);
    pulse_break();
    sample();
    check("glitch_done", int'(frame_done), 1);
    check("glitch_frame_slots", int'(frame_slots), 1);

    // Framing error on slot 1
    bw = wa_q.size();
    bd = done_cnt;
    be = err_cnt;
    pulse_break();
    tick(4);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b0);
    tick(4);
    sample();
    check("ferr_error_pulses", err_cnt - be, 1);
    check("ferr_writes", wa_q.size() - bw, 0);
    check("ferr_busy", int'(busy), 0);
    check("ferr_frame_slots", int'(frame_slots), 1);
    check("ferr_done_count", done_cnt - bd, 0);

    // Break arriving four bits into slot 3
    bw = wa_q.size();
    pulse_break();
    tick(4);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    pulse_break();
    sample();
    check("mid_done", int'(frame_done), 1);
    check("mid_frame_slots", int'(frame_slots), 2);
    check("mid_writes", wa_q.size() - bw, 2);
    bw = wa_q.size();
    tick(4);
    send_byte(8'h00, 1'b1);
    send_byte(8'h99, 1'b1);
    tick(4);
    sample();
    check("mid_next_writes", wa_q.size() - bw, 1);
    if (wa_q.size() > bw) begin
      check("mid_next_addr", int'(wa_q[bw]), 0);
      check("mid_next_data", int'(wd_q[bw]), 'h99);
    end
    pulse_break();
    sample();
    check("mid_next_frame_slots", int'(frame_slots), 1);

    // Reset asserted in the middle of a slot
    bw = wa_q.size();
    bd = done_cnt;
    tick(4);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(1);
    sample();
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_frame_slots", int'(frame_slots), 0);
    check("rst_mid_start_code", int'(start_code), 0);
    rst_n = 1'b1;
    tick(BITC * 8);
    sample();
    check("rst_mid_writes", wa_q.size() - bw, 0);
    check("rst_mid_done_count", done_cnt - bd, 0);

    check("done_error_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
